// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmitter among
// N_REQ byte requesters, with message ownership and a wait-state timeout.
module uart_tx_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 tx_en,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 err_timeout
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // Abort on the edge where the counter would step onto TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ownerIdx;
    logic [PTR_W-1:0]   ownerNext;
    logic [CNT_W-1:0]   cnt;
    logic               lastLatched;
    logic               winValid;
    logic [PTR_W-1:0]   winIdx;
    logic [PTR_W-1:0]   candIdx;

    // Round-robin winner search starting at ptr.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            candIdx = PTR_W'((32'(ptr) + 32'(k)) % N_REQ);
            if (!winValid && req_valid[candIdx]) begin
                winValid = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // Pointer value that follows the current owner.
    always_comb begin
        ownerNext = ownerIdx + PTR_W'(1);
        if (32'(ownerIdx) + 32'd1 == N_REQ) begin
            ownerNext = '0;
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (res_n) begin
            state       <= IDLE;
            ptr         <= '0;
            ownerIdx    <= '0;
            cnt         <= '0;
            lastLatched <= 1'b0;
            req_ready   <= '0;
            grant       <= '0;
            tx_en       <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
        end else begin
            tx_en       <= 1'b1;
            req_ready   <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (winValid) begin
                        ownerIdx    <= winIdx;
                        tx_data     <= req_data[{winIdx, 3'b000} +: 8];
                        lastLatched <= req_last[winIdx];
                        req_ready   <= N_REQ'(1) << winIdx;
                        grant       <= N_REQ'(1) << winIdx;
                        tx_start    <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (tx_done) begin
                        tx_start <= 1'b0;
                        if (lastLatched) begin
                            grant <= '0;
                            ptr   <= ownerNext;
                            state <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (state == WAIT_BUSY && tx_busy) begin
                        tx_start <= 1'b0;
                        cnt      <= '0;
                        state    <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        tx_start    <= 1'b0;
                        grant       <= '0;
                        ptr         <= ownerNext;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (req_valid[ownerIdx]) begin
                        tx_data     <= req_data[{ownerIdx, 3'b000} +: 8];
                        lastLatched <= req_last[ownerIdx];
                        req_ready   <= N_REQ'(1) << ownerIdx;
                        tx_start    <= 1'b1;
                        state       <= START;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenario bench for uart_tx_scheduler.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        res_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        tx_en;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic        err_timeout;

    int checkCount;
    int passCount;

    uart_tx_scheduler #(.N_REQ(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_en      (tx_en),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        res_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        step();
        step();
        res_n = 1'b0;
        step();
    endtask

    // From a START cycle: busy, then done, ending just after the done edge.
    task automatic serveFrame();
        step();
        tx_busy = 1'b1;
        step();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        res_n     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'hDEADBEEF;
        req_last  = 4'b1111;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        step();
        step();
        checkCount++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else passCount++;
        checkCount++;
        if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else passCount++;
        checkCount++;
        if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else passCount++;
        checkCount++;
        if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passCount++;
        checkCount++;
        if (tx_en !== 1'b0) $display("FAIL reset_tx_en: got %b want 0", tx_en); else passCount++;
        checkCount++;
        if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", err_timeout); else passCount++;
        req_valid = '0;
        res_n = 1'b0;
        step();
        checkCount++;
        if (tx_en !== 1'b1) $display("FAIL tx_en_after_reset: got %b want 1", tx_en); else passCount++;
    endtask

    task automatic test_round_robin();
        doReset();
        req_valid = 4'b0101;
        req_data  = 32'h004C_0041;
        req_last  = 4'b1111;
        step();
        checkCount++;
        if (req_ready !== 4'b0001) $display("FAIL rr_ready0: got %b want 0001", req_ready); else passCount++;
        checkCount++;
        if (grant !== 4'b0001) $display("FAIL rr_grant0: got %b want 0001", grant); else passCount++;
        checkCount++;
        if (tx_data !== 8'h41 || tx_start !== 1'b1) $display("FAIL rr_byte0: got data %h start %b want 41 1", tx_data, tx_start); else passCount++;
        req_valid = 4'b0100;
        step();
        checkCount++;
        if (req_ready !== 4'b0000 || tx_start !== 1'b1) $display("FAIL rr_wait_busy: got ready %b start %b want 0000 1", req_ready, tx_start); else passCount++;
        tx_busy = 1'b1;
        step();
        checkCount++;
        if (tx_start !== 1'b0 || tx_data !== 8'h41) $display("FAIL rr_wait_done: got start %b data %h want 0 41", tx_start, tx_data); else passCount++;
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checkCount++;
        if (grant !== 4'b0000) $display("FAIL rr_release: got %b want 0000", grant); else passCount++;
        step();
        checkCount++;
        if (req_ready !== 4'b0100 || grant !== 4'b0100) $display("FAIL rr_ready2: got ready %b grant %b want 0100 0100", req_ready, grant); else passCount++;
        checkCount++;
        if (tx_data !== 8'h4C) $display("FAIL rr_byte2: got %h want 4c", tx_data); else passCount++;
        req_valid = '0;
        serveFrame();
    endtask

    task automatic test_hold();
        doReset();
        req_valid = 4'b1010;
        req_data  = 32'h3300_5100;
        req_last  = 4'b1000;
        step();
        checkCount++;
        if (req_ready !== 4'b0010 || tx_data !== 8'h51) $display("FAIL hold_first: got ready %b data %h want 0010 51", req_ready, tx_data); else passCount++;
        req_valid = 4'b1000;
        serveFrame();
        checkCount++;
        if (grant !== 4'b0010) $display("FAIL hold_grant: got %b want 0010", grant); else passCount++;
        step();
        checkCount++;
        if (req_ready !== 4'b0000 || grant !== 4'b0010) $display("FAIL hold_ignore: got ready %b grant %b want 0000 0010", req_ready, grant); else passCount++;
        req_valid = 4'b1010;
        req_data  = 32'h3300_4100;
        req_last  = 4'b1010;
        step();
        checkCount++;
        if (req_ready !== 4'b0010 || tx_data !== 8'h41) $display("FAIL hold_second: got ready %b data %h want 0010 41", req_ready, tx_data); else passCount++;
        req_valid = 4'b1000;
        serveFrame();
        checkCount++;
        if (grant !== 4'b0000) $display("FAIL hold_release: got %b want 0000", grant); else passCount++;
        step();
        checkCount++;
        if (req_ready !== 4'b1000 || tx_data !== 8'h33) $display("FAIL hold_next_owner: got ready %b data %h want 1000 33", req_ready, tx_data); else passCount++;
        req_valid = '0;
        serveFrame();
    endtask

    task automatic test_timeout();
        int highCycles;
        doReset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_005A;
        req_last  = 4'b1111;
        step();
        req_valid = '0;
        highCycles = (tx_start === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && tx_start === 1'b1; i++) begin
            step();
            if (tx_start === 1'b1) highCycles++;
        end
        checkCount++;
        if (highCycles != 16) $display("FAIL to_start_cycles: got %0d want 16", highCycles); else passCount++;
        checkCount++;
        if (err_timeout !== 1'b1 || grant !== 4'b0000) $display("FAIL to_abort: got err %b grant %b want 1 0000", err_timeout, grant); else passCount++;
        step();
        checkCount++;
        if (err_timeout !== 1'b0) $display("FAIL to_single_pulse: got %b want 0", err_timeout); else passCount++;
        req_valid = 4'b0011;
        req_data  = 32'h0000_2211;
        step();
        checkCount++;
        if (req_ready !== 4'b0010 || tx_data !== 8'h22) $display("FAIL to_ptr_advance: got ready %b data %h want 0010 22", req_ready, tx_data); else passCount++;
        req_valid = '0;
        serveFrame();
    endtask

    task automatic test_reset_mid();
        doReset();
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        req_last  = 4'b1111;
        step();
        req_valid = '0;
        step();
        tx_busy = 1'b1;
        step();
        res_n = 1'b1;
        step();
        checkCount++;
        if (tx_start !== 1'b0 || grant !== 4'b0000 || tx_en !== 1'b0) $display("FAIL mid_reset: got start %b grant %b en %b want 0 0000 0", tx_start, grant, tx_en); else passCount++;
        checkCount++;
        if (err_timeout !== 1'b0 || req_ready !== 4'b0000) $display("FAIL mid_reset_pulses: got err %b ready %b want 0 0000", err_timeout, req_ready); else passCount++;
        res_n     = 1'b0;
        tx_busy   = 1'b0;
        req_valid = 4'b0101;
        req_data  = 32'h0020_0010;
        step();
        checkCount++;
        if (req_ready !== 4'b0001 || tx_data !== 8'h10) $display("FAIL mid_reset_first: got ready %b data %h want 0001 10", req_ready, tx_data); else passCount++;
        req_valid = '0;
        serveFrame();
    endtask

    task automatic test_done_at_timeout();
        doReset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0066;
        req_last  = 4'b1111;
        step();
        req_valid = '0;
        step();
        for (int i = 0; i < 14; i++) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checkCount++;
        if (err_timeout !== 1'b0) $display("FAIL coincide_err: got %b want 0", err_timeout); else passCount++;
        checkCount++;
        if (grant !== 4'b0000 || tx_start !== 1'b0) $display("FAIL coincide_done: got grant %b start %b want 0000 0", grant, tx_start); else passCount++;
        step();
        checkCount++;
        if (err_timeout !== 1'b0) $display("FAIL coincide_err_late: got %b want 0", err_timeout); else passCount++;
        req_valid = 4'b0011;
        req_data  = 32'h0000_2211;
        step();
        checkCount++;
        if (req_ready !== 4'b0010) $display("FAIL coincide_ptr: got %b want 0010", req_ready); else passCount++;
        req_valid = '0;
        serveFrame();
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        test_reset();
        test_round_robin();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_done_at_timeout();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4: number of requesters sharing one UART transmitter (range 2..8).
REQ-002 The module SHALL have parameter TIMEOUT, default 2000000: clk cycles allowed in WAIT_BUSY or WAIT_DONE before abort.
REQ-003 The module SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port res_n, input, 1: synchronous, active-high reset (asserted = 1).
REQ-005 The module SHALL have port req_valid, input, N_REQ: bit i = requester i presents a byte.
REQ-006 The module SHALL have port req_data, input, 8*N_REQ: byte of requester i at bits [8i+7:8i].
REQ-007 The module SHALL have port req_last, input, N_REQ: bit i = presented byte ends requester i's message.
REQ-008 The module SHALL have port req_ready, output, N_REQ: one-cycle accept pulse per byte.
REQ-009 The module SHALL have port grant, output, N_REQ: one-hot current owner, all zero when unowned.
REQ-010 The module SHALL have port tx_en, output, 1: transmitter enable.
REQ-011 The module SHALL have port tx_start, output, 1: transmit request to the UART.
REQ-012 The module SHALL have port tx_data, output, 8: byte to the UART.
REQ-013 The module SHALL have port tx_busy, input, 1: UART transmitting.
REQ-014 The module SHALL have port tx_done, input, 1: UART finished frame (pulse or level).
REQ-015 The module SHALL have port err_timeout, output, 1: one-cycle pulse on abort.

Function
REQ-016 The module SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-017 In IDLE with any req_valid=1, the module SHALL select winner w by round-robin from pointer ptr upward (mod N_REQ), latch req_data[w] and req_last[w], pulse req_ready[w], set grant to one-hot w, and enter START next cycle.
REQ-018 A byte SHALL transfer only in a cycle with req_valid[i]=1 and req_ready[i]=1; requesters hold valid/data until then.
REQ-019 In START and WAIT_BUSY, the module SHALL hold tx_start=1; tx_data SHALL equal the latched byte from START through WAIT_DONE.
REQ-020 START SHALL last exactly one cycle, then go to WAIT_BUSY.
REQ-021 In WAIT_BUSY, on tx_busy=1 the module SHALL drop tx_start and enter WAIT_DONE.
REQ-022 In WAIT_BUSY, on tx_done=1 (with or without tx_busy) the module SHALL treat the frame as complete, drop tx_start, and apply REQ-023.
REQ-023 In WAIT_DONE on tx_done=1: if latched last=1, the module SHALL clear grant, set ptr=(w+1) mod N_REQ, and enter IDLE; else enter HOLD.
REQ-024 In HOLD, the module SHALL ignore all requesters except w; on req_valid[w]=1, latch its byte/last, pulse req_ready[w], and enter START.
REQ-025 HOLD SHALL have no timeout; the owner keeps the transmitter until it sends a byte with req_last=1.
REQ-026 The cycle counter SHALL clear on entry to WAIT_BUSY and WAIT_DONE.
REQ-027 If the counter reaches TIMEOUT-1 in either wait state, the module SHALL pulse err_timeout, drop tx_start, clear grant, set ptr=(w+1) mod N_REQ, and enter IDLE.
REQ-028 If tx_done and a timeout coincide, tx_done SHALL win and no err_timeout is raised.
REQ-029 req_ready SHALL pulse at most once per granted byte and never to a non-owner.
REQ-030 tx_en SHALL be 1 in every cycle when not in reset.
REQ-031 A requester deasserting req_valid before acceptance SHALL lose nothing; arbitration re-evaluates each IDLE cycle.

Reset
REQ-032 While res_n=1 at a rising edge, next-cycle outputs SHALL be req_ready=0, grant=0, tx_start=0, tx_data=0, tx_en=0, err_timeout=0; state=IDLE, ptr=0, counter=0.
REQ-033 Reset mid-operation in any state SHALL abort at once with no completion or timeout pulse; the aborted byte is discarded.

Verification
REQ-034 After reset, req_valid=4'b0101, data0=0x41, data2=0x4C, last=1 -> req_ready[0] pulses first, 0x41 sent; after tx_done, req_ready[2] pulses, 0x4C sent.
REQ-035 Requester 1 sends 0x51 (last=0) then 0x41 (last=1) while requester 3 is valid -> grant stays 4'b0010 across both bytes; requester 3 is served only after the second tx_done.
REQ-036 tx_busy is never raised, TIMEOUT=16 -> tx_start is high for 16 cycles, then err_timeout pulses once, grant=0, ptr advances.
REQ-037 res_n=1 asserted during WAIT_DONE -> next cycle tx_start=0, grant=0, tx_en=0; after release, requester 0 is served first.
REQ-038 tx_done on the same edge as the counter reaching TIMEOUT-1 -> no err_timeout; normal completion per REQ-023.
